// File: rtl/ip_msx50bus_host.sv
// Host-side MSX 50-pin bus engine: turns single-cycle internal requests into
// timed memory/I/O read/write cycles on a cartridge slot, honouring n_wait.
module ip_msx50bus_host #(
    parameter int SETUP_CYCLES  = 2,
    parameter int STROBE_CYCLES = 4,
    parameter int HOLD_CYCLES   = 1
) (
    input  logic        clk,
    input  logic        n_reset,
    input  logic [15:0] bus_address,
    input  logic        bus_io_req,
    input  logic        bus_memory_req,
    output logic        bus_ack,
    input  logic        bus_wrt,
    input  logic [7:0]  bus_wdata,
    output logic [7:0]  bus_rdata,
    output logic        bus_rdata_en,
    output logic        busy,
    output logic [15:0] adr,
    output logic [7:0]  o_data,
    output logic        is_output,
    input  logic [7:0]  i_data,
    output logic        n_sltsl,
    output logic        n_mereq,
    output logic        n_ioreq,
    output logic        n_rd,
    output logic        n_wr,
    input  logic        n_wait
);

    localparam logic [3:0] SETUP_LOAD  = 4'(SETUP_CYCLES - 1);
    localparam logic [3:0] STROBE_LOAD = 4'(STROBE_CYCLES - 1);
    localparam logic [3:0] HOLD_LOAD   = 4'(HOLD_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, SETUP, STROBE, HOLD} state_t;

    state_t     state;
    logic [3:0] count;
    logic       cyc_write;
    logic       wait_meta;
    logic       wait_sync;
    logic       w_wait;

    // n_wait comes straight from the cartridge connector, so it is resynchronised
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            wait_meta <= 1'b1;
            wait_sync <= 1'b1;
        end else begin
            wait_meta <= n_wait;
            wait_sync <= wait_meta;
        end
    end

    assign w_wait = ~wait_sync;

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state        <= IDLE;
            count        <= 4'd0;
            cyc_write    <= 1'b0;
            bus_ack      <= 1'b0;
            bus_rdata    <= 8'h00;
            bus_rdata_en <= 1'b0;
            busy         <= 1'b0;
            adr          <= 16'h0000;
            o_data       <= 8'h00;
            is_output    <= 1'b0;
            n_sltsl      <= 1'b1;
            n_mereq      <= 1'b1;
            n_ioreq      <= 1'b1;
            n_rd         <= 1'b1;
            n_wr         <= 1'b1;
        end else begin
            bus_ack      <= 1'b0;
            bus_rdata_en <= 1'b0;
            case (state)
                IDLE: begin
                    // I/O wins a tie; the memory request simply stays pending
                    if (bus_io_req || bus_memory_req) begin
                        cyc_write <= bus_wrt;
                        adr       <= bus_address;
                        if (bus_wrt) begin
                            o_data    <= bus_wdata;
                            is_output <= 1'b1;
                        end
                        n_ioreq <= ~bus_io_req;
                        n_sltsl <= bus_io_req;
                        n_mereq <= bus_io_req;
                        bus_ack <= 1'b1;
                        busy    <= 1'b1;
                        count   <= SETUP_LOAD;
                        state   <= SETUP;
                    end
                end
                SETUP: begin
                    if (count == 4'd0) begin
                        n_rd  <= cyc_write;
                        n_wr  <= ~cyc_write;
                        count <= STROBE_LOAD;
                        state <= STROBE;
                    end else begin
                        count <= count - 4'd1;
                    end
                end
                STROBE: begin
                    // a waiting cartridge freezes the counter wherever it is
                    if (!w_wait) begin
                        if (count == 4'd0) begin
                            n_rd <= 1'b1;
                            n_wr <= 1'b1;
                            if (!cyc_write) begin
                                bus_rdata    <= i_data;
                                bus_rdata_en <= 1'b1;
                            end
                            count <= HOLD_LOAD;
                            state <= HOLD;
                        end else begin
                            count <= count - 4'd1;
                        end
                    end
                end
                HOLD: begin
                    if (count == 4'd0) begin
                        n_sltsl   <= 1'b1;
                        n_mereq   <= 1'b1;
                        n_ioreq   <= 1'b1;
                        is_output <= 1'b0;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end else begin
                        count <= count - 4'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
